// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr/Count/Compare/Status/Cause/EPC, the Count/Compare timer,
// exception-entry/ERET commit and interrupt-request generation.
module cp0_regfile #(
  parameter bit          COUNT_HALF_RATE = 1'b1,
  parameter int unsigned TIMER_IP_BIT    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_cp0_r_addr,
  output logic [31:0] ex_cp0_r_data,
  input  logic        w_cp0_ena,
  input  logic [7:0]  w_cp0_addr,
  input  logic [31:0] w_cp0_data,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_is_eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_epc,
  output logic        cp0_int_req,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause
);

  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] TIMER_MASK    = 8'(1) << TIMER_IP_BIT;

  logic [31:0] badvaddr_q, count_q, compare_q, epc_q;
  logic [7:0]  status_im_q;
  logic        status_exl_q, status_ie_q;
  logic        cause_bd_q, cause_ti_q;
  logic [5:0]  cause_ip_hw_q;
  logic [1:0]  cause_ip_sw_q;
  logic [4:0]  cause_exc_q;
  logic        tick_phase_q, count_inc_q;

  logic        exc_take, eret_take, tick, ti_set;
  logic        wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [7:0]  cause_ip;

  assign exc_take  = exc_valid & ~exc_is_eret;
  assign eret_take = exc_valid &  exc_is_eret;

  assign wr_badvaddr = w_cp0_ena && (w_cp0_addr == ADDR_BADVADDR);
  assign wr_count    = w_cp0_ena && (w_cp0_addr == ADDR_COUNT);
  assign wr_compare  = w_cp0_ena && (w_cp0_addr == ADDR_COMPARE);
  assign wr_status   = w_cp0_ena && (w_cp0_addr == ADDR_STATUS);
  assign wr_cause    = w_cp0_ena && (w_cp0_addr == ADDR_CAUSE);
  assign wr_epc      = w_cp0_ena && (w_cp0_addr == ADDR_EPC);

  assign tick = COUNT_HALF_RATE ? tick_phase_q : 1'b1;
  // Compare==0 matches only when Count actually stepped into it, so reset state never fires.
  assign ti_set = (count_q == compare_q) && ((compare_q != '0) || count_inc_q);

  assign cause_ip    = {cause_ip_hw_q, cause_ip_sw_q} | (cause_ti_q ? TIMER_MASK : '0);
  assign cp0_status  = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
  assign cp0_cause   = {cause_bd_q, cause_ti_q, 14'b0, cause_ip, 1'b0, cause_exc_q, 2'b0};
  assign cp0_epc     = epc_q;
  assign cp0_int_req = status_ie_q & ~status_exl_q & (|(cause_ip & status_im_q));

  always_comb begin
    ex_cp0_r_data = '0;
    case (ex_cp0_r_addr)
      ADDR_BADVADDR: ex_cp0_r_data = badvaddr_q;
      ADDR_COUNT:    ex_cp0_r_data = count_q;
      ADDR_COMPARE:  ex_cp0_r_data = compare_q;
      ADDR_STATUS:   ex_cp0_r_data = cp0_status;
      ADDR_CAUSE:    ex_cp0_r_data = cp0_cause;
      ADDR_EPC:      ex_cp0_r_data = epc_q;
      default:       ex_cp0_r_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_q    <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      epc_q         <= '0;
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ti_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      tick_phase_q  <= 1'b0;
      count_inc_q   <= 1'b0;
    end else begin
      tick_phase_q  <= ~tick_phase_q;
      cause_ip_hw_q <= hw_int;
      count_inc_q   <= tick & ~wr_count;

      if (wr_count)  count_q <= w_cp0_data;
      else if (tick) count_q <= count_q + 32'd1;

      if (wr_compare) begin
        compare_q  <= w_cp0_data;
        cause_ti_q <= 1'b0;
      end else if (ti_set) begin
        cause_ti_q <= 1'b1;
      end

      if (wr_status) begin
        status_im_q <= w_cp0_data[15:8];
        status_ie_q <= w_cp0_data[0];
      end
      if (exc_take)       status_exl_q <= 1'b1;
      else if (eret_take) status_exl_q <= 1'b0;
      else if (wr_status) status_exl_q <= w_cp0_data[1];

      if (wr_cause) cause_ip_sw_q <= w_cp0_data[9:8];

      // An exception owns EPC for its cycle even when EXL blocks the EPC update.
      if (exc_take) begin
        cause_exc_q <= exc_code;
        if (!status_exl_q) begin
          epc_q      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          cause_bd_q <= exc_bd;
        end
      end else if (wr_epc) begin
        epc_q <= w_cp0_data;
      end

      if (exc_take && (exc_code == 5'd4 || exc_code == 5'd5)) badvaddr_q <= exc_badvaddr;
      else if (wr_badvaddr)                                    badvaddr_q <= w_cp0_data;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: stimulus queues expected values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_cp0_regfile;

  localparam int SEL_RD = 0, SEL_EPC = 1, SEL_INT = 2, SEL_STATUS = 3, SEL_CAUSE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ex_cp0_r_addr = '0;
  logic [31:0] ex_cp0_r_data;
  logic        w_cp0_ena = 1'b0;
  logic [7:0]  w_cp0_addr = '0;
  logic [31:0] w_cp0_data = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        exc_is_eret = 1'b0;
  logic [5:0]  hw_int = '0;
  logic [31:0] cp0_epc, cp0_status, cp0_cause;
  logic        cp0_int_req;

  cp0_regfile #(.COUNT_HALF_RATE(1'b1), .TIMER_IP_BIT(7)) dut (
    .clk(clk), .rst(rst),
    .ex_cp0_r_addr(ex_cp0_r_addr), .ex_cp0_r_data(ex_cp0_r_data),
    .w_cp0_ena(w_cp0_ena), .w_cp0_addr(w_cp0_addr), .w_cp0_data(w_cp0_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .exc_is_eret(exc_is_eret), .hw_int(hw_int),
    .cp0_epc(cp0_epc), .cp0_int_req(cp0_int_req),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int edges = 0;
  int wedge = 0;

  // Clock edges since reset release; Count ticks on the even ones.
  always @(posedge clk) if (rst) edges = edges + 1;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_entry_t e;
      logic [31:0] got;
      e = sb.pop_front();
      case (e.sel)
        SEL_RD:     got = ex_cp0_r_data;
        SEL_EPC:    got = cp0_epc;
        SEL_INT:    got = {31'b0, cp0_int_req};
        SEL_STATUS: got = cp0_status;
        default:    got = cp0_cause;
      endcase
      n_vec++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    sb.push_back('{sel, exp, name});
  endtask

  task automatic chk_rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
    ex_cp0_r_addr = addr;
    sb.push_back('{SEL_RD, exp, name});
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    w_cp0_ena = 1'b1; w_cp0_addr = addr; w_cp0_data = data;
    cyc();
    w_cp0_ena = 1'b0;
  endtask

  task automatic take_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic [31:0] bva, input logic eret);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badvaddr = bva; exc_is_eret = eret;
    cyc();
    exc_valid = 1'b0; exc_is_eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc();
    // Reset state, read while reset is still held so Count cannot move.
    chk_rd(8'h40, 32'h0, "rst_badvaddr"); cyc();
    chk_rd(8'h48, 32'h0, "rst_count");    cyc();
    chk_rd(8'h58, 32'h0, "rst_compare");  cyc();
    chk_rd(8'h60, 32'h0040_0000, "rst_status"); cyc();
    chk_rd(8'h68, 32'h0, "rst_cause");    cyc();
    chk_rd(8'h70, 32'h0, "rst_epc");
    chk(SEL_INT, 32'h0, "rst_int_req");
    chk(SEL_STATUS, 32'h0040_0000, "rst_status_out");
    chk(SEL_CAUSE, 32'h0, "rst_cause_out");
    chk(SEL_EPC, 32'h0, "rst_epc_out");
    cyc();
    rst = 1'b1;

    mtc0(8'h60, 32'hFFFF_FFFF);
    chk_rd(8'h60, 32'h0040_FF03, "status_mask");
    chk(SEL_INT, 32'h0, "int_masked_by_exl");
    cyc();
    mtc0(8'h68, 32'hFFFF_FFFF);
    chk_rd(8'h68, 32'h0000_0300, "cause_mask");
    cyc();
    mtc0(8'h68, 32'h0);
    mtc0(8'h60, 32'h0);
    mtc0(8'h78, 32'hDEAD_BEEF);
    chk_rd(8'h78, 32'h0, "unmapped_read");
    cyc();

    // Timer
    mtc0(8'h48, 32'h0);
    wedge = edges;
    mtc0(8'h58, 32'd5);
    mtc0(8'h60, 32'h0000_8001);
    repeat (10) cyc();
    chk_rd(8'h48, 32'(edges / 2 - wedge / 2), "count_half_rate");
    chk(SEL_CAUSE, 32'h4000_8000, "cause_ti");
    chk(SEL_INT, 32'h1, "timer_int_req");
    cyc();
    mtc0(8'h58, 32'd20);
    chk(SEL_CAUSE, 32'h0, "ti_cleared");
    chk(SEL_INT, 32'h0, "timer_int_cleared");
    chk_rd(8'h58, 32'd20, "compare_read");
    cyc();
    mtc0(8'h58, 32'h1000_0000);

    // Exceptions
    take_exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h3, 1'b0);
    chk(SEL_EPC, 32'hBFC0_0100, "exc_epc_bd");
    chk(SEL_CAUSE, 32'h8000_0010, "exc_cause");
    chk(SEL_STATUS, 32'h0040_8003, "exc_exl");
    chk(SEL_INT, 32'h0, "exc_int_masked");
    chk_rd(8'h40, 32'h3, "exc_badvaddr");
    cyc();
    take_exc(5'd8, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
    chk(SEL_EPC, 32'hBFC0_0100, "nested_epc_hold");
    chk(SEL_CAUSE, 32'h8000_0020, "nested_cause");
    chk_rd(8'h40, 32'h3, "nested_badvaddr_hold");
    cyc();
    take_exc(5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk(SEL_STATUS, 32'h0040_8001, "eret_status");
    chk(SEL_EPC, 32'hBFC0_0100, "eret_epc");
    chk(SEL_CAUSE, 32'h8000_0020, "eret_cause");
    cyc();

    w_cp0_ena = 1'b1; w_cp0_addr = 8'h70; w_cp0_data = 32'h0000_1234;
    take_exc(5'd8, 32'h0000_0400, 1'b0, 32'h0, 1'b0);
    w_cp0_ena = 1'b0;
    chk(SEL_EPC, 32'h0000_0400, "exc_beats_mtc0_epc");
    chk(SEL_CAUSE, 32'h0000_0020, "sys_cause");
    chk(SEL_STATUS, 32'h0040_8003, "sys_status");
    cyc();
    take_exc(5'd0, 32'h0, 1'b0, 32'h0, 1'b1);

    w_cp0_ena = 1'b1; w_cp0_addr = 8'h60; w_cp0_data = 32'h0000_0401;
    take_exc(5'd12, 32'h0000_0500, 1'b0, 32'h0, 1'b0);
    w_cp0_ena = 1'b0;
    chk(SEL_STATUS, 32'h0040_0403, "mtc0_status_with_exc");
    chk(SEL_EPC, 32'h0000_0500, "ov_epc");
    chk(SEL_CAUSE, 32'h0000_0030, "ov_cause");
    cyc();
    take_exc(5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk(SEL_STATUS, 32'h0040_0401, "eret_status2");

    // Hardware interrupt, one cycle of sampling latency each way
    hw_int = 6'b000001;
    chk(SEL_INT, 32'h0, "hw_int_not_yet");
    cyc();
    chk(SEL_INT, 32'h1, "hw_int_req");
    chk(SEL_CAUSE, 32'h0000_0430, "hw_int_cause");
    cyc();
    hw_int = 6'b000000;
    chk(SEL_INT, 32'h1, "hw_int_drop_latency");
    cyc();
    chk(SEL_INT, 32'h0, "hw_int_cleared");
    chk(SEL_CAUSE, 32'h0000_0030, "hw_int_cause_cleared");
    chk_rd(8'h48, 32'(edges / 2 - wedge / 2), "count_final");
    cyc();
    cyc();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      n_bad = n_bad + sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
